// File: rtl/mcdt_out_buf_if.sv
// Stream bundle between mcdt, the output buffer and the downstream stage.
// The slave modport is the buffer's view: it consumes the mcdt side and drives the ready/valid side.
interface mcdt_out_buf_if #(
  parameter int DW = 32
);
  logic [DW-1:0] mcdt_data_i;
  logic          mcdt_val_i;
  logic [1:0]    mcdt_id_i;
  logic [DW-1:0] out_data_o;
  logic [1:0]    out_id_o;
  logic          out_valid_o;
  logic          out_ready_i;

  modport slave (
    input  mcdt_data_i, mcdt_val_i, mcdt_id_i, out_ready_i,
    output out_data_o, out_id_o, out_valid_o
  );

  modport master (
    output mcdt_data_i, mcdt_val_i, mcdt_id_i, out_ready_i,
    input  out_data_o, out_id_o, out_valid_o
  );
endinterface

// File: rtl/mcdt_out_buf.sv
// Output buffer for mcdt: tagged FWFT FIFO with valid/ready egress,
// per-channel saturating counters and sticky overflow / bad-id flags.
module mcdt_out_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  mcdt_out_buf_if.slave            bus,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o,
  output logic [CW-1:0]            ch0_cnt_o,
  output logic [CW-1:0]            ch1_cnt_o,
  output logic [CW-1:0]            ch2_cnt_o,
  output logic [CW-1:0]            drop_cnt_o,
  output logic                     ovf_o,
  output logic                     id_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CTR_ONE = CW'(1);

  logic [DW+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW+1:0] head;
  logic          empty;
  logic          full;
  logic          id_ok;
  logic          push;
  logic          pop;
  logic          drop_full;
  logic          drop_id;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CTR_ONE;
  endfunction

  assign empty     = (fifo_cnt_o == '0);
  assign full      = (fifo_cnt_o == CNT_FULL);
  assign id_ok     = (bus.mcdt_id_i != 2'd3);
  assign pop       = !empty && bus.out_ready_i;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push      = bus.mcdt_val_i && id_ok && (!full || pop);
  assign drop_full = bus.mcdt_val_i && id_ok && full && !pop;
  assign drop_id   = bus.mcdt_val_i && !id_ok;

  assign head            = mem[rd_ptr];
  assign bus.out_valid_o = !empty;
  assign bus.out_data_o  = empty ? '0 : head[DW-1:0];
  assign bus.out_id_o    = empty ? 2'd0 : head[DW+1:DW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt_o <= '0;
      ch0_cnt_o  <= '0;
      ch1_cnt_o  <= '0;
      ch2_cnt_o  <= '0;
      drop_cnt_o <= '0;
      ovf_o      <= 1'b0;
      id_err_o   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.mcdt_id_i, bus.mcdt_data_i};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   fifo_cnt_o <= fifo_cnt_o + CNT_ONE;
        2'b01:   fifo_cnt_o <= fifo_cnt_o - CNT_ONE;
        default: fifo_cnt_o <= fifo_cnt_o;
      endcase

      // Clear has priority over any same-cycle count or flag update.
      if (clr_i) begin
        ch0_cnt_o  <= '0;
        ch1_cnt_o  <= '0;
        ch2_cnt_o  <= '0;
        drop_cnt_o <= '0;
        ovf_o      <= 1'b0;
        id_err_o   <= 1'b0;
      end else begin
        if (push) begin
          case (bus.mcdt_id_i)
            2'd0:    ch0_cnt_o <= sat_inc(ch0_cnt_o);
            2'd1:    ch1_cnt_o <= sat_inc(ch1_cnt_o);
            2'd2:    ch2_cnt_o <= sat_inc(ch2_cnt_o);
            default: ;
          endcase
        end
        if (drop_full || drop_id) drop_cnt_o <= sat_inc(drop_cnt_o);
        if (drop_full) ovf_o <= 1'b1;
        if (drop_id) id_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcdt_out_buf.sv
// Directed bench for mcdt_out_buf: ordering, overflow, full-with-pop, bad id,
// async reset mid-stream and clear priority, with hand-computed expectations.
module tb_mcdt_out_buf;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int CW    = 16;

  logic          clk;
  logic          rst;
  logic          clr;
  logic [4:0]    fifo_cnt;
  logic [CW-1:0] ch0_cnt;
  logic [CW-1:0] ch1_cnt;
  logic [CW-1:0] ch2_cnt;
  logic [CW-1:0] drop_cnt;
  logic          ovf;
  logic          id_err;

  int checks = 0;
  int errors = 0;

  mcdt_out_buf_if #(.DW(DW)) bus ();

  mcdt_out_buf #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .bus        (bus),
    .fifo_cnt_o (fifo_cnt),
    .ch0_cnt_o  (ch0_cnt),
    .ch1_cnt_o  (ch1_cnt),
    .ch2_cnt_o  (ch2_cnt),
    .drop_cnt_o (drop_cnt),
    .ovf_o      (ovf),
    .id_err_o   (id_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic val, input logic [1:0] id,
                               input logic [DW-1:0] data, input logic ready);
    bus.mcdt_val_i  = val;
    bus.mcdt_id_i   = id;
    bus.mcdt_data_i = data;
    bus.out_ready_i = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCounters(input string tag, input int c0, input int c1,
                               input int c2, input int dr, input logic o,
                               input logic ie);
    checkOutput({tag, " ch0"}, 64'(ch0_cnt), 64'(c0));
    checkOutput({tag, " ch1"}, 64'(ch1_cnt), 64'(c1));
    checkOutput({tag, " ch2"}, 64'(ch2_cnt), 64'(c2));
    checkOutput({tag, " drop"}, 64'(drop_cnt), 64'(dr));
    checkOutput({tag, " ovf"}, 64'(ovf), 64'(o));
    checkOutput({tag, " id_err"}, 64'(id_err), 64'(ie));
  endtask

  task automatic pulseClear();
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("reset valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("reset cnt", 64'(fifo_cnt), 64'd0);
    checkOutput("reset data", 64'(bus.out_data_o), 64'd0);
    checkCounters("reset", 0, 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Three words with ready held high: each one shows right after its push edge
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'(i), 32'h00C0_0000 + 32'(i) * 32'h0001_0000, 1'b1);
      tick();
      checkOutput("pass valid", 64'(bus.out_valid_o), 64'd1);
      checkOutput("pass data", 64'(bus.out_data_o), 64'(32'h00C0_0000 + 32'(i) * 32'h0001_0000));
      checkOutput("pass id", 64'(bus.out_id_o), 64'(i));
      checkOutput("pass cnt", 64'(fifo_cnt), 64'd1);
    end
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    tick();
    checkOutput("pass drained cnt", 64'(fifo_cnt), 64'd0);
    checkOutput("pass drained valid", 64'(bus.out_valid_o), 64'd0);
    checkCounters("pass", 1, 1, 1, 0, 1'b0, 1'b0);

    // Fill to 16 with ready low, then one more word overflows
    pulseClear();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'd1, 32'h00C1_0000 + 32'(i), 1'b0);
      tick();
    end
    checkOutput("fill cnt", 64'(fifo_cnt), 64'd16);
    checkOutput("fill head", 64'(bus.out_data_o), 64'h00C1_0000);
    applyStimulus(1'b1, 2'd1, 32'h00C1_0010, 1'b0);
    tick();
    checkOutput("ovf cnt", 64'(fifo_cnt), 64'd16);
    checkCounters("ovf", 0, 16, 0, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("ovf drain data", 64'(bus.out_data_o), 64'(32'h00C1_0000 + 32'(i)));
      tick();
    end
    checkOutput("ovf drain cnt", 64'(fifo_cnt), 64'd0);

    // Full FIFO with simultaneous push and pop across the pointer wrap
    pulseClear();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'(i % 3), 32'h00A0_0000 + 32'(i), 1'b0);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 2'd2, 32'h00B0_0000 + 32'(j), 1'b1);
      tick();
      checkOutput("fullpp cnt", 64'(fifo_cnt), 64'd16);
      checkOutput("fullpp head", 64'(bus.out_data_o), 64'(32'h00A0_0000 + 32'(j + 1)));
    end
    checkOutput("fullpp ovf", 64'(ovf), 64'd0);
    checkOutput("fullpp drop", 64'(drop_cnt), 64'd0);
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    for (int i = 4; i < 20; i++) begin
      checkOutput("fullpp drain", 64'(bus.out_data_o),
                  64'(i < 16 ? 32'h00A0_0000 + 32'(i) : 32'h00B0_0000 + 32'(i - 16)));
      tick();
    end
    checkOutput("fullpp empty", 64'(bus.out_valid_o), 64'd0);

    // Illegal channel id is dropped regardless of space
    pulseClear();
    applyStimulus(1'b1, 2'd3, 32'hDEAD_BEEF, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    checkOutput("badid valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("badid cnt", 64'(fifo_cnt), 64'd0);
    checkCounters("badid", 0, 0, 0, 1, 1'b0, 1'b1);

    // Async reset between edges with five words buffered
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'(i % 3), 32'h0050_0000 + 32'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    checkOutput("prerst cnt", 64'(fifo_cnt), 64'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("arst cnt", 64'(fifo_cnt), 64'd0);
    checkCounters("arst", 0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 2'd2, 32'h5555_0001, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    checkOutput("postrst data", 64'(bus.out_data_o), 64'h5555_0001);
    checkOutput("postrst id", 64'(bus.out_id_o), 64'd2);
    checkOutput("postrst cnt", 64'(fifo_cnt), 64'd1);

    // Clear in the same cycle as an id-0 push while ovf is set
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 2'd0, 32'h6600_0000 + 32'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 2'd0, 32'h6600_00FF, 1'b0);
    tick();
    checkCounters("preclr", 15, 0, 1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    tick();
    checkOutput("preclr cnt", 64'(fifo_cnt), 64'd15);
    applyStimulus(1'b1, 2'd0, 32'h7777_0000, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    checkOutput("clr cnt", 64'(fifo_cnt), 64'd16);
    checkCounters("clr", 0, 0, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcdt_out_buf.md
Name: mcdt_out_buf

Overview:
- Sits directly downstream of mcdt and consumes its arbitrated output stream (data, valid, 2-bit channel id).
- mcdt has no backpressure, so this block absorbs every word into a FIFO that keeps each word's channel tag.
- Re-presents words to the next stage over a valid/ready handshake.
- Keeps per-channel accepted-word counters and sticky error flags for overflow and bad channel id.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
DW, 32, data width
CW, 16, width of per-channel counters

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset, asynchronous, active-high; one clock, async active-high reset
mcdt_data_i  in  DW  word from mcdt
mcdt_val_i  in  1  word present this cycle; no ready returned
mcdt_id_i  in  2  source channel 0..2; 3 is illegal
out_data_o  out  DW  head-of-FIFO data
out_id_o  out  2  head-of-FIFO channel id
out_valid_o  out  1  head word valid
out_ready_i  in  1  downstream accepts head word
fifo_cnt_o  out  $clog2(DEPTH)+1  current occupancy
ch0_cnt_o  out  CW  words accepted from channel 0
ch1_cnt_o  out  CW  words accepted from channel 1
ch2_cnt_o  out  CW  words accepted from channel 2
drop_cnt_o  out  CW  words dropped for any reason
ovf_o  out  1  sticky: a word was dropped because the FIFO was full
id_err_o  out  1  sticky: a word arrived with id 3
clr_i  in  1  synchronous clear of all counters and sticky flags

Behaviour:
- Reset (rst_i=1, takes effect immediately):
  - pointers and fifo_cnt_o = 0, so out_valid_o = 0;
  - all counters = 0; ovf_o = 0, id_err_o = 0;
  - out_data_o and out_id_o = 0 while empty.
- Reset asserted mid-operation discards all buffered words. No output may glitch high after rst_i rises.
- Storage: entries of {id, data}, DW+2 bits. Write and read pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 to 0.
- Pop: occurs when out_valid_o && out_ready_i at a rising edge.
- Push: occurs when mcdt_val_i && mcdt_id_i != 3 && (fifo_cnt_o < DEPTH || pop).
  - Full plus simultaneous pop still accepts the write, with no loss.
- Occupancy: fifo_cnt_o updates by +1 (push only), -1 (pop only), or 0 (both or neither).
- Output is first-word-fall-through:
  - out_valid_o = (fifo_cnt_o != 0);
  - out_data_o and out_id_o come from the entry at the read pointer.
- Latency: a word pushed at edge k into an empty FIFO shows on the outputs right after edge k, with out_valid_o = 1 in the same cycle. There is no combinational path from mcdt_val_i to out_valid_o.
- While out_valid_o && !out_ready_i, out_data_o and out_id_o hold stable.
- out_ready_i while empty has no effect.
- Drop, full: mcdt_val_i with a legal id, FIFO full and no pop.
  - The word is discarded; ovf_o is set; drop_cnt_o increments.
- Drop, bad id: mcdt_val_i with id 3.
  - The word is discarded regardless of occupancy; id_err_o is set; drop_cnt_o increments; no channel counter changes.
- Counters:
  - chN_cnt_o increments on each push whose id is N.
  - All counters saturate at all-ones and never wrap.
- clr_i:
  - At the edge, zeroes ch0..2_cnt_o and drop_cnt_o, and clears ovf_o and id_err_o.
  - clr_i wins over a same-cycle increment or set.
  - clr_i does not touch FIFO contents or fifo_cnt_o.
- No state machine beyond the FIFO: the block is pointer/count-sequenced. Implementation is a single always_ff with async reset, plus combinational push/pop decode.

Test Plan:
- Reset, then 3 words are pushed on consecutive cycles (ids 0,1,2, data 00C0_0000, 00C1_0000, 00C2_0000) with out_ready_i=1.
  -> Each word appears the cycle after its push, in order, with matching out_id_o.
  -> ch0/1/2_cnt_o = 1 each; fifo_cnt_o returns to 0.
- out_ready_i=0 while 16 words (id 1, 00C1_0000+i) are pushed, then a 17th word arrives.
  -> fifo_cnt_o=16; the 17th word is dropped; ovf_o=1, drop_cnt_o=1, ch1_cnt_o=16.
  -> Draining yields exactly 00C1_0000..00C1_000F.
- FIFO full, mcdt_val_i and out_ready_i both high for 4 cycles.
  -> No drops; ovf_o stays 0; fifo_cnt_o stays 16; output order is preserved across the pointer wrap.
- Word with id 3, data DEAD_BEEF.
  -> Not stored; id_err_o=1; drop_cnt_o=1; channel counters unchanged; out_valid_o stays 0.
- 5 words buffered, then rst_i pulsed asynchronously between edges.
  -> out_valid_o=0 and fifo_cnt_o=0 immediately; all counters and flags are 0.
  -> The next pushed word is the first word output.
- clr_i asserted in the same cycle as an id-0 push, with ovf_o already set.
  -> The word is stored; ch0_cnt_o=0 after the edge; ovf_o=0; fifo_cnt_o increments by 1.
